// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for 8 requesters with a registered one-hot
// grant, its encoded index, and a starvation guard that preempts an owner
// holding longer than MAX_HOLD cycles while someone else is waiting.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 4,   // 0 = never preempt
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       switch
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nxt;
  logic [2:0]        ptr, ptr_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [7:0]        gnt_nxt;
  logic [2:0]        idx_nxt;
  logic              sw_nxt;

  logic [7:0]        others;
  logic [3:0]        pick_idle, pick_hand;
  logic              release_own, preempt;

  // First set bit of r scanning start, start+1, ... (mod 8).
  // Result is {found, index}. Scanning backwards lets the nearest hit win.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] i;
    res = '0;
    for (int k = 7; k >= 0; k--) begin
      i = start + 3'(k);
      if (r[i]) res = {1'b1, i};
    end
    return res;
  endfunction

  // Request view seen by the handoff search: the owner is excluded so a
  // preempted owner still asserting req cannot win straight back.
  always_comb begin
    others      = req & ~(8'b1 << gnt_idx);
    pick_idle   = rr_pick(req, ptr);
    pick_hand   = rr_pick(others, gnt_idx + 3'd1);
    release_own = ~req[gnt_idx];
    preempt     = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1)) && (|others);
  end

  // Next-state / next-grant decision.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt;
    idx_nxt   = gnt_idx;
    sw_nxt    = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        idx_nxt = '0;
        if (pick_idle[3]) begin
          state_nxt = GRANT;
          gnt_nxt   = 8'b1 << pick_idle[2:0];
          idx_nxt   = pick_idle[2:0];
          sw_nxt    = 1'b1;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (release_own || preempt) begin
          ptr_nxt  = gnt_idx + 3'd1;
          hold_nxt = '0;
          if (pick_hand[3]) begin
            // back-to-back handoff, no idle bubble
            gnt_nxt = 8'b1 << pick_hand[2:0];
            idx_nxt = pick_hand[2:0];
            sw_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            idx_nxt   = '0;
          end
        end else if (hold_cnt != '1) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // State and output registers; reset release is expected to be synchronised
  // upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_idx  <= '0;
      switch   <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      gnt_idx  <= idx_nxt;
      switch   <= sw_nxt;
    end
  end

  assign gnt_valid = |gnt;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed vectors for rr_arbiter8. Stimulus pushes the
// expected outputs for the following edge into a scoreboard; the monitor pops
// and compares after every rising edge.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       switch;

  rr_arbiter8 #(.MAX_HOLD(4), .HOLD_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .switch(switch)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       sw;
  } exp_t;

  exp_t sb[$];
  int   tcyc  = 0;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, tcyc, act, exp);
    end
  endtask

  function automatic logic [2:0] enc(input logic [7:0] g);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  // Drive req for the next edge and record what that edge must produce.
  task automatic step(input logic [7:0] r, input logic [7:0] eg, input logic esw);
    exp_t e;
    @(negedge clk);
    req   = r;
    e.cyc = tcyc + 1;
    e.gnt = eg;
    e.idx = enc(eg);
    e.vld = |eg;
    e.sw  = esw;
    sb.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_idx"}, gnt_idx, 0);
    chk({tag, "_vld"}, gnt_valid, 0);
    chk({tag, "_sw"},  switch, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    #1 chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare every due expectation just after the edge.
  always @(posedge clk) begin
    exp_t e;
    tcyc++;
    #1;
    while (sb.size() > 0 && sb[0].cyc <= tcyc) begin
      e = sb.pop_front();
      if (e.cyc < tcyc) begin
        chk("stale_exp", 32'(e.cyc), 32'(tcyc));
      end else begin
        chk("gnt",       gnt,       e.gnt);
        chk("gnt_idx",   gnt_idx,   e.idx);
        chk("gnt_valid", gnt_valid, e.vld);
        chk("switch",    switch,    e.sw);
      end
    end
    chk("inv_onehot0", 32'($onehot0(gnt)), 1);
    chk("inv_idx_enc", gnt_idx, enc(gnt));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end by itself");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 chk_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // idle, nothing requested
    repeat (5) step(8'h00, 8'h00, 1'b0);

    // sole requester: granted in one cycle, never preempted
    step(8'h10, 8'h10, 1'b1);
    repeat (20) step(8'h10, 8'h10, 1'b0);
    step(8'h00, 8'h00, 1'b0);

    // all requesting: 4-cycle slots 0..7,0, back-to-back
    do_reset();
    for (int n = 0; n < 36; n++)
      step(8'hFF, 8'h01 << ((n / 4) % 8), (n % 4) == 0);
    step(8'h00, 8'h00, 1'b0);                  // ptr -> 1

    // owner 2 drops, handoff to 5, then 5 drops to idle
    step(8'h24, 8'h04, 1'b1);
    step(8'h24, 8'h04, 1'b0);
    step(8'h20, 8'h20, 1'b1);
    step(8'h20, 8'h20, 1'b0);
    step(8'h00, 8'h00, 1'b0);                  // ptr -> 6

    // wrap-around search 6,7,0 then release to 1
    step(8'h03, 8'h01, 1'b1);
    step(8'h03, 8'h01, 1'b0);
    step(8'h02, 8'h02, 1'b1);
    step(8'h02, 8'h02, 1'b0);

    // owner 1 preempted after 4 cycles, 0 served, 1 rejoins
    step(8'h03, 8'h02, 1'b0);
    step(8'h03, 8'h02, 1'b0);
    step(8'h03, 8'h01, 1'b1);
    repeat (3) step(8'h03, 8'h01, 1'b0);
    step(8'h03, 8'h02, 1'b1);
    repeat (2) step(8'h03, 8'h02, 1'b0);
    step(8'h00, 8'h00, 1'b0);                  // ptr -> 2

    // async reset mid-grant
    step(8'h80, 8'h80, 1'b1);
    step(8'h80, 8'h80, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    req = 8'h00;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    // ptr back at 0: 1 beats 7 (ptr 2 would have picked 7)
    step(8'h82, 8'h02, 1'b1);
    step(8'h80, 8'h80, 1'b1);
    step(8'h00, 8'h00, 1'b0);

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
